conv_result_streamer: RTL and testbench

//   Read-side drain for the convolution engine's result vector.
//   - On start, takes a snapshot of the engine's flat 256x64-bit result bus (y).
//   - Streams the first len elements, one 64-bit word per beat, over a valid/ready

---
 rtl/conv_result_streamer.sv | 121 ++++++++++++
 tb/tb_conv_result_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_streamer.sv
// Snapshot-and-drain streamer: captures the convolution engine's result vector
// on start and streams the first len elements over a valid/ready master port.
// Optional build macro: CONV_STREAM_PARITY_EN adds the m_parity output.
module conv_result_streamer #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 64,
  parameter int IDX_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IDX_W-1:0]        len,
  input  logic [DEPTH*DATA_W-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic [IDX_W-1:0]        m_idx,
  output logic                    m_last
`ifdef CONV_STREAM_PARITY_EN
  ,
  output logic                    m_parity
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] snap [DEPTH];
  logic [IDX_W-1:0]  cnt;

  logic [IDX_W-1:0]  next_idx;
  logic [DATA_W-1:0] next_data;
  logic              next_last;
  logic              xfer;
  logic              capture;

  // NOTE: every always_comb output is assigned unconditionally so no latch is inferred.
  always_comb begin
    next_idx  = m_idx + IDX_W'(1);
    next_data = snap[next_idx];
    next_last = (next_idx == cnt - IDX_W'(1));
    xfer      = m_valid && m_ready;
    capture   = (state == IDLE) && start && (len != '0);
  end

  // NOTE: the snapshot is cleared on reset so results of an aborted job can never leak
  // into a later stream; this costs a reset on every storage bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) snap[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < DEPTH; k++) snap[k] <= y_in[k*DATA_W +: DATA_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_idx    <= '0;
      m_last   <= 1'b0;
`ifdef CONV_STREAM_PARITY_EN
      m_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              cnt   <= len;
              m_idx <= '0;
              state <= LOAD;
            end else begin
              state <= FIN;
            end
          end
        end
        LOAD: begin
          m_data   <= snap[0];
          m_idx    <= '0;
          m_valid  <= 1'b1;
          m_last   <= (cnt == IDX_W'(1));
`ifdef CONV_STREAM_PARITY_EN
          m_parity <= ^snap[0];
`endif
          state    <= STREAM;
        end
        STREAM: begin
          // Without a handshake the word and its sideband hold still.
          if (xfer) begin
            if (m_last) begin
              m_valid <= 1'b0;
              state   <= FIN;
            end else begin
              m_data   <= next_data;
              m_idx    <= next_idx;
              m_last   <= next_last;
`ifdef CONV_STREAM_PARITY_EN
              m_parity <= ^next_data;
`endif
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == STREAM);
  assign done = (state == FIN);

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: a scoreboard queue holds the beats each
// job should produce and is drained against the DUT's valid/ready output.
module tb_conv_result_streamer;

  localparam int DEPTH  = 256;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 8;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic [IDX_W-1:0]        len;
  logic [DEPTH*DATA_W-1:0] y_in;
  logic                    busy;
  logic                    done;
  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_W-1:0]       m_data;
  logic [IDX_W-1:0]        m_idx;
  logic                    m_last;
`ifdef CONV_STREAM_PARITY_EN
  logic                    m_parity;
`endif

  conv_result_streamer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .y_in    (y_in),
    .busy    (busy),
    .done    (done),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last)
`ifdef CONV_STREAM_PARITY_EN
    ,
    .m_parity(m_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic              par;
  } beat_t;

  beat_t             sb [$];
  logic [DATA_W-1:0] y_arr [DEPTH];
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_y();
    for (int k = 0; k < DEPTH; k++) y_in[k*DATA_W +: DATA_W] = y_arr[k];
  endtask

  task automatic push_job(input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = y_arr[k];
      b.idx  = IDX_W'(k);
      b.last = (k == n - 1);
      b.par  = ($countones(y_arr[k]) % 2) == 1;
      sb.push_back(b);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle following the start cycle.
  task automatic pulse_start(input int n);
    start = 1'b1;
    len   = IDX_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic take_beat(input string tag);
    beat_t e;
    e = sb.pop_front();
    check({tag, "_data"}, m_data, e.data);
    check({tag, "_idx"},  64'(m_idx), 64'(e.idx));
    check({tag, "_last"}, 64'(m_last), 64'(e.last));
`ifdef CONV_STREAM_PARITY_EN
    check({tag, "_par"},  64'(m_parity), 64'(e.par));
`endif
  endtask

  // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input int budget, input string tag,
                       output int first_n, output int last_n);
    bit                finished;
    bit                stalled;
    logic [DATA_W-1:0] hold_d;
    logic [IDX_W-1:0]  hold_i;
    logic              hold_l;
    first_n  = -1;
    last_n   = -1;
    finished = 0;
    stalled  = 0;
    hold_d   = '0;
    hold_i   = '0;
    hold_l   = 1'b0;
    for (int n = 0; n < budget && !finished; n++) begin
      m_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      if (m_valid) begin
        if (first_n < 0) begin
          first_n = n;
          check({tag, "_busy"}, 64'(busy), 64'd1);
        end
        if (stalled) begin
          check({tag, "_stall_data"}, m_data, hold_d);
          check({tag, "_stall_idx"},  64'(m_idx), 64'(hold_i));
          check({tag, "_stall_last"}, 64'(m_last), 64'(hold_l));
        end
        if (sb.size() == 0) begin
          check({tag, "_extra_beat"}, 64'(m_valid), 64'd0);
        end else if (m_ready) begin
          take_beat(tag);
          stalled = 0;
          last_n  = n;
          if (sb.size() == 0) finished = 1;
        end else begin
          stalled = 1;
          hold_d  = m_data;
          hold_i  = m_idx;
          hold_l  = m_last;
        end
      end
      @(negedge clk);
    end
    if (!finished) begin
      check({tag, "_timeout_pending"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end else begin
      check({tag, "_done"},      64'(done),    64'd1);
      check({tag, "_busy_fin"},  64'(busy),    64'd0);
      check({tag, "_valid_fin"}, 64'(m_valid), 64'd0);
    end
  endtask

  int first_n;
  int last_n;

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    len     = '0;
    m_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) y_arr[k] = 64'h4000_0000_0000_0000 + 64'(k);
    set_y();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",  64'(busy),    64'd0);
    check("rst_done",  64'(done),    64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last",  64'(m_last),  64'd0);
    check("rst_data",  m_data,       64'd0);
    check("rst_idx",   64'(m_idx),   64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: len=4, ready held high, back-to-back beats
    push_job(4);
    pulse_start(4);
    check("t1_load_valid", 64'(m_valid), 64'd0);
    check("t1_load_busy",  64'(busy),    64'd1);
    drain(0, 20, "t1", first_n, last_n);
    check("t1_latency", 64'(first_n), 64'd1);
    check("t1_span",    64'(last_n - first_n), 64'd3);
    check("t1_done_once", 64'(done), 64'd1);
    @(negedge clk);
    check("t1_done_low", 64'(done), 64'd0);
    check("t1_busy_low", 64'(busy), 64'd0);

    // 2: len=3 with ready pattern 1,0,0
    for (int k = 0; k < DEPTH; k++) y_arr[k] = 64'hC0DE_0000_0000_0000 ^ (64'(k) << 8);
    set_y();
    push_job(3);
    pulse_start(3);
    drain(1, 40, "t2", first_n, last_n);
    @(negedge clk);
    check("t2_busy_low", 64'(busy), 64'd0);

    // 3: len=0 job produces only a done pulse
    m_ready = 1'b1;
    pulse_start(0);
    check("t3_done",  64'(done),    64'd1);
    check("t3_busy",  64'(busy),    64'd0);
    check("t3_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("t3_done_low",  64'(done),    64'd0);
    check("t3_valid_low", 64'(m_valid), 64'd0);

    // 4: inputs changed and start pulsed mid-stream are ignored
    for (int k = 0; k < DEPTH; k++) y_arr[k] = 64'h1111_2222_0000_0000 + 64'(k * 7);
    set_y();
    push_job(5);
    pulse_start(5);
    m_ready = 1'b0;
    @(negedge clk);
    check("t4_first_valid", 64'(m_valid), 64'd1);
    for (int k = 0; k < DEPTH; k++) y_arr[k] = 64'hDEAD_BEEF_0000_0000 + 64'(k);
    set_y();
    start = 1'b1;
    len   = IDX_W'(2);
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_hold", 64'(busy), 64'd1);
    drain(0, 20, "t4", first_n, last_n);
    @(negedge clk);
    check("t4_no_second_job", 64'({done, m_valid, busy}), 64'd0);

    // 5: reset asserted mid-stream with a beat stalled
    for (int k = 0; k < DEPTH; k++) y_arr[k] = 64'h0F0F_0000_0000_0000 | 64'(k);
    set_y();
    push_job(8);
    pulse_start(8);
    m_ready = 1'b1;
    @(negedge clk);
    check("t5_b0_valid", 64'(m_valid), 64'd1);
    take_beat("t5_b0");
    @(negedge clk);
    take_beat("t5_b1");
    @(negedge clk);
    m_ready = 1'b0;
    check("t5_b2_valid", 64'(m_valid), 64'd1);
    check("t5_b2_idx",   64'(m_idx),   64'd2);
    #1 reset = 1'b0;
    #1;
    check("t5_rst_valid", 64'(m_valid), 64'd0);
    check("t5_rst_busy",  64'(busy),    64'd0);
    check("t5_rst_done",  64'(done),    64'd0);
    check("t5_rst_data",  m_data,       64'd0);
    check("t5_rst_idx",   64'(m_idx),   64'd0);
    check("t5_rst_last",  64'(m_last),  64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_quiet", 64'({done, m_valid, busy}), 64'd0);
    end
    y_arr[0] = 64'h3FF0_0000_0000_0005;
    set_y();
    push_job(1);
    pulse_start(1);
    drain(0, 10, "t5_after", first_n, last_n);
    @(negedge clk);

    // 6: parity pattern (m_parity checked when the port exists)
    y_arr[0] = 64'h1;
    y_arr[1] = 64'h3;
    set_y();
    push_job(2);
    pulse_start(2);
    drain(0, 10, "t6", first_n, last_n);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
